// File: rtl/rv_pkg.sv
// Shared writeback definitions: register index / data widths and the
// encoding used to name a writeback source.
package rv_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_LD  = 1'b1
  } wb_src_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-requester writeback arbiter: round-robin on last_grant, or load-wins
// when FIXED_PRIO is set (ALU may starve under continuous load traffic).
module rr_arb2
  import rv_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    req_alu,
  input  logic    req_ld,
  output logic    gnt_alu,
  output logic    gnt_ld,
  output wb_src_t gnt_src
);

  wb_src_t last_grant;

  always_comb begin
    gnt_alu = 1'b0;
    gnt_ld  = 1'b0;
    if (req_alu && req_ld) begin
      if ((FIXED_PRIO != 0) || (last_grant == WB_ALU)) gnt_ld = 1'b1;
      else gnt_alu = 1'b1;
    end else begin
      gnt_alu = req_alu;
      gnt_ld  = req_ld;
    end
  end

  assign gnt_src = gnt_ld ? WB_LD : WB_ALU;

  // A grant is only ever given to a valid requester, so every grant is a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= WB_LD;
    end else if ((FIXED_PRIO == 0) && (gnt_alu || gnt_ld)) begin
      last_grant <= gnt_src;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register file write port between the ALU and load writeback
// paths; registers the winning write, tracks pending writes, counts conflicts.
module regfile_wr_arbiter
  import rv_pkg::*;
#(
  parameter int NREGS      = 32,
  parameter int AW         = REG_IDX_W,
  parameter int DW         = XLEN,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [AW-1:0]    alu_rd,
  input  logic [DW-1:0]    alu_data,
  output logic             alu_ready,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_rd,
  input  logic [DW-1:0]    ld_data,
  output logic             ld_ready,
  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             rf_we,
  output logic [AW-1:0]    rf_wa,
  output logic [DW-1:0]    rf_wd,
  output logic [NREGS-1:0] busy,
  output logic [CNT_W-1:0] conflict_cnt
);

  wb_src_t          gnt_src;
  logic             xfer;
  logic             wr_en;
  logic [AW-1:0]    wb_rd;
  logic [DW-1:0]    wb_data;
  logic [NREGS-1:0] busy_nxt;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_alu (alu_valid),
    .req_ld  (ld_valid),
    .gnt_alu (alu_ready),
    .gnt_ld  (ld_ready),
    .gnt_src (gnt_src)
  );

  assign xfer    = alu_ready || ld_ready;
  assign wb_rd   = (gnt_src == WB_LD) ? ld_rd : alu_rd;
  assign wb_data = (gnt_src == WB_LD) ? ld_data : alu_data;
  // Writes to x0 are accepted but never reach the register file.
  assign wr_en   = xfer && (wb_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
    end else begin
      rf_we <= wr_en;
      if (wr_en) begin
        rf_wa <= wb_rd;
        rf_wd <= wb_data;
      end
    end
  end

  // Set is applied after clear so a newly issued producer stays pending.
  always_comb begin
    busy_nxt = busy;
    if (wr_en && (int'(wb_rd) < NREGS)) busy_nxt[wb_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0) && (int'(iss_rd) < NREGS)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt <= '0;
    end else if (alu_valid && ld_valid && (conflict_cnt != '1)) begin
      conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: three instances (round-robin, fixed priority,
// 4-bit counter) driven in lockstep and compared against a behavioural model.
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, ld_valid, iss_valid;
  logic [4:0]  alu_rd, ld_rd, iss_rd;
  logic [31:0] alu_data, ld_data;

  logic        ar [3];
  logic        lr [3];
  logic        we [3];
  logic [4:0]  wa [3];
  logic [31:0] wd [3];
  logic [31:0] bz [3];
  logic [15:0] cn [3];
  logic [3:0]  cnt_c4;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.FIXED_PRIO(0)) dut_rr (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(ar[0]),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(lr[0]),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(we[0]), .rf_wa(wa[0]), .rf_wd(wd[0]), .busy(bz[0]), .conflict_cnt(cn[0])
  );

  regfile_wr_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(ar[1]),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(lr[1]),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(we[1]), .rf_wa(wa[1]), .rf_wd(wd[1]), .busy(bz[1]), .conflict_cnt(cn[1])
  );

  regfile_wr_arbiter #(.FIXED_PRIO(0), .CNT_W(4)) dut_c4 (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(ar[2]),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(lr[2]),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(we[2]), .rf_wa(wa[2]), .rf_wd(wd[2]), .busy(bz[2]), .conflict_cnt(cnt_c4)
  );
  assign cn[2] = {12'd0, cnt_c4};

  // Reference model: one entry per instance. Grant code 0=none, 1=ALU, 2=LD.
  int          m_fixed [3] = '{0, 1, 0};
  int          m_cmax  [3] = '{65535, 65535, 15};
  int          m_last  [3];
  bit          m_busy  [3][32];
  bit          m_we    [3];
  int          m_wa    [3];
  logic [31:0] m_wd    [3];
  int          m_cnt   [3];
  int          last_g  [3];
  logic        smp_ar  [3];
  logic        smp_lr  [3];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int mgnt(int i);
    if (alu_valid && ld_valid) return (m_fixed[i] != 0 || m_last[i] == 1) ? 2 : 1;
    if (alu_valid) return 1;
    if (ld_valid) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] mbusy(int i);
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_busy[i][r];
    return v;
  endfunction

  task automatic mreset();
    for (int i = 0; i < 3; i++) begin
      m_last[i] = 2;
      for (int r = 0; r < 32; r++) m_busy[i][r] = 1'b0;
      m_we[i] = 1'b0; m_wa[i] = 0; m_wd[i] = '0; m_cnt[i] = 0; last_g[i] = 0;
    end
  endtask

  task automatic mstep(int i, int g);
    int rd;
    m_we[i] = 1'b0;
    if (g != 0) begin
      rd = (g == 1) ? int'(alu_rd) : int'(ld_rd);
      if (m_fixed[i] == 0) m_last[i] = g;
      if (rd != 0) begin
        m_we[i] = 1'b1;
        m_wa[i] = rd;
        m_wd[i] = (g == 1) ? alu_data : ld_data;
        m_busy[i][rd] = 1'b0;
      end
    end
    if (iss_valid && iss_rd != 0) m_busy[i][iss_rd] = 1'b1;
    if (alu_valid && ld_valid && m_cnt[i] < m_cmax[i]) m_cnt[i]++;
  endtask

  // Called 1 time unit after a rising edge with inputs already driven.
  task automatic cycle();
    int g [3];
    #1;
    for (int i = 0; i < 3; i++) begin
      g[i] = mgnt(i);
      smp_ar[i] = ar[i];
      smp_lr[i] = lr[i];
      chk($sformatf("alu_ready[%0d]", i), ar[i], g[i] == 1);
      chk($sformatf("ld_ready[%0d]", i), lr[i], g[i] == 2);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) mstep(i, g[i]);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rf_we[%0d]", i), we[i], m_we[i]);
      chk($sformatf("rf_wa[%0d]", i), wa[i], m_wa[i]);
      chk($sformatf("rf_wd[%0d]", i), wd[i], m_wd[i]);
      chk($sformatf("busy[%0d]", i), bz[i], mbusy(i));
      chk($sformatf("conflict_cnt[%0d]", i), cn[i], m_cnt[i]);
      last_g[i] = g[i];
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; ld_valid = 1'b0; iss_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_rf_we[%0d]", i), we[i], 1'b0);
      chk($sformatf("rst_busy[%0d]", i), bz[i], 32'd0);
      chk($sformatf("rst_cnt[%0d]", i), cn[i], 16'd0);
    end
    mreset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    alu_rd = '0; ld_rd = '0; iss_rd = '0; alu_data = '0; ld_data = '0;
    mreset();
    @(posedge clk);
    #1;
    chk("init_rf_we", we[0], 1'b0);
    chk("init_rf_wa", wa[0], 5'd0);
    chk("init_rf_wd", wd[0], 32'd0);
    chk("init_busy", bz[0], 32'd0);
    chk("init_cnt", cn[0], 16'd0);
    reset = 1'b0;

    // Reset mid-traffic: busy[4] pending and a write in flight.
    iss_valid = 1'b1; iss_rd = 5'd4;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h1234_5678;
    cycle();
    chk("mid_rf_we", we[0], 1'b1);
    chk("mid_busy", bz[0], 32'h0000_0010);
    idle();
    do_reset();

    // Single ALU write to x5.
    iss_valid = 1'b1; iss_rd = 5'd5;
    cycle();
    chk("iss5_busy", bz[0][5], 1'b1);
    idle();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    cycle();
    chk("alu5_ready", smp_ar[0], 1'b1);
    chk("alu5_rf_we", we[0], 1'b1);
    chk("alu5_rf_wa", wa[0], 5'd5);
    chk("alu5_rf_wd", wd[0], 32'hDEAD_BEEF);
    chk("alu5_busy", bz[0][5], 1'b0);
    idle();
    cycle();
    chk("hold_rf_we", we[0], 1'b0);
    chk("hold_rf_wd", wd[0], 32'hDEAD_BEEF);

    // Tie for 4 cycles: round-robin alternates from ALU, fixed picks LD.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA000_0001;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'hB000_0002;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk($sformatf("rr_tie_alu%0d", k), smp_ar[0], (k % 2) == 0);
      chk($sformatf("rr_tie_ld%0d", k), smp_lr[0], (k % 2) == 1);
      chk($sformatf("fp_tie_alu%0d", k), smp_ar[1], 1'b0);
      chk($sformatf("fp_tie_ld%0d", k), smp_lr[1], 1'b1);
      alu_data = alu_data + 32'd1;
      ld_data  = ld_data + 32'd1;
    end
    chk("rr_tie_cnt", cn[0], 16'd4);
    ld_valid = 1'b0;
    cycle();
    chk("fp_alu_after_ld_drop", smp_ar[1], 1'b1);
    idle();

    // Load to x0 is accepted without a write.
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFF_FFFF;
    cycle();
    chk("x0_ld_ready", smp_lr[0], 1'b1);
    chk("x0_rf_we", we[0], 1'b0);
    idle();
    // Same-register set/clear: the newer issue keeps x7 pending.
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
    iss_valid = 1'b1; iss_rd = 5'd7;
    cycle();
    chk("race_busy7", bz[0][7], 1'b1);
    chk("race_rf_we", we[0], 1'b1);
    idle();

    // Counter saturation on the 4-bit instance.
    alu_valid = 1'b1; ld_valid = 1'b1;
    for (int k = 0; k < 20; k++) cycle();
    chk("c4_saturated", cn[2], 16'd15);
    idle();

    // Randomized traffic; an unaccepted request is held stable.
    for (int k = 0; k < 400; k++) begin
      if (!alu_valid || last_g[0] == 1) begin
        alu_valid = 1'($urandom);
        alu_rd    = 5'($urandom);
        alu_data  = $urandom;
      end
      if (!ld_valid || last_g[0] == 2) begin
        ld_valid = 1'($urandom);
        ld_rd    = 5'($urandom);
        ld_data  = $urandom;
      end
      iss_valid = 1'($urandom);
      iss_rd    = 5'($urandom);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
